// File: rtl/alu_writeback_if.sv
// Upstream ALU result bus plus register-file write and exception outputs of the writeback stage.
`timescale 1ns/1ps
interface alu_writeback_if #(
   parameter int unsigned REG_DATA_WIDTH    = 16,
   parameter int unsigned REG_ADDR_WIDTH    = 4,
   parameter int unsigned ALU_CONTROL_WIDTH = 4,
   parameter int unsigned EXC_CNT_WIDTH     = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic [ALU_CONTROL_WIDTH-1:0] alu_control;
   logic [REG_DATA_WIDTH-1:0]    r;
   logic [REG_DATA_WIDTH-1:0]    s;
   logic                         exc_alu;
   logic [REG_ADDR_WIDTH-1:0]    rd;
   logic                         wb_en;
   logic                         rf_we;
   logic [REG_ADDR_WIDTH-1:0]    rf_waddr;
   logic [REG_DATA_WIDTH-1:0]    rf_wdata;
   logic                         exc_pulse;
   logic [EXC_CNT_WIDTH-1:0]     exc_count;

   modport master (
      output in_valid, alu_control, r, s, exc_alu, rd, wb_en,
      input  in_ready, rf_we, rf_waddr, rf_wdata, exc_pulse, exc_count
   );

   modport slave (
      input  in_valid, alu_control, r, s, exc_alu, rd, wb_en,
      output in_ready, rf_we, rf_waddr, rf_wdata, exc_pulse, exc_count
   );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: sequences lower/upper result writes into a single-port
// register file, suppresses writes of faulting ops and counts exceptions.
`timescale 1ns/1ps
module alu_writeback #(
   parameter int unsigned REG_DATA_WIDTH    = 16,
   parameter int unsigned REG_ADDR_WIDTH    = 4,
   parameter int unsigned ALU_CONTROL_WIDTH = 4,
   parameter int unsigned HI_REG            = 0,
   parameter int unsigned EXC_CNT_WIDTH     = 8
) (
   input logic             clk,
   input logic             rst,
   alu_writeback_if.slave  bus
);
   localparam logic [ALU_CONTROL_WIDTH-1:0] OP_NOP  = ALU_CONTROL_WIDTH'(0);
   localparam logic [ALU_CONTROL_WIDTH-1:0] OP_MUL  = ALU_CONTROL_WIDTH'(1);
   localparam logic [ALU_CONTROL_WIDTH-1:0] OP_DIV  = ALU_CONTROL_WIDTH'(2);
   localparam logic [REG_ADDR_WIDTH-1:0]    HI_ADDR = REG_ADDR_WIDTH'(HI_REG);

   typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, EXC} state_t;

   state_t                      state, state_nxt;
   logic                        hi_pend, hi_pend_nxt;
   logic [REG_DATA_WIDTH-1:0]   s_hold, s_hold_nxt;
   logic                        rf_we, rf_we_nxt;
   logic [REG_ADDR_WIDTH-1:0]   rf_waddr, rf_waddr_nxt;
   logic [REG_DATA_WIDTH-1:0]   rf_wdata, rf_wdata_nxt;
   logic                        exc_pulse, exc_pulse_nxt;
   logic [EXC_CNT_WIDTH-1:0]    exc_count, exc_count_nxt;
   logic                        ready_c;
   logic                        accept_c;
   logic                        wide_op_c;

   // Only the first write of a MUL/DIV blocks the input: the upper write is already committed.
   assign ready_c   = !((state == WR_LO) && hi_pend);
   assign accept_c  = bus.in_valid && ready_c;
   assign wide_op_c = (bus.alu_control == OP_MUL) || (bus.alu_control == OP_DIV);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         hi_pend   <= 1'b0;
         s_hold    <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         exc_pulse <= 1'b0;
         exc_count <= '0;
      end else begin
         state     <= state_nxt;
         hi_pend   <= hi_pend_nxt;
         s_hold    <= s_hold_nxt;
         rf_we     <= rf_we_nxt;
         rf_waddr  <= rf_waddr_nxt;
         rf_wdata  <= rf_wdata_nxt;
         exc_pulse <= exc_pulse_nxt;
         exc_count <= exc_count_nxt;
      end
   end

   // Outputs are computed for the state being entered, so each state drives its own write.
   always_comb begin
      state_nxt     = IDLE;
      hi_pend_nxt   = 1'b0;
      s_hold_nxt    = s_hold;
      rf_we_nxt     = 1'b0;
      rf_waddr_nxt  = rf_waddr;
      rf_wdata_nxt  = rf_wdata;
      exc_pulse_nxt = 1'b0;
      exc_count_nxt = exc_count;
      if ((state == WR_LO) && hi_pend) begin
         state_nxt    = WR_HI;
         rf_we_nxt    = 1'b1;
         rf_waddr_nxt = HI_ADDR;
         rf_wdata_nxt = s_hold;
      end else if (accept_c) begin
         if (bus.exc_alu) begin
            state_nxt     = EXC;
            exc_pulse_nxt = 1'b1;
            exc_count_nxt = (&exc_count) ? exc_count : exc_count + EXC_CNT_WIDTH'(1);
         end else if (!bus.wb_en || (bus.alu_control == OP_NOP)) begin
            state_nxt = IDLE;
         end else begin
            state_nxt    = WR_LO;
            hi_pend_nxt  = wide_op_c;
            s_hold_nxt   = bus.s;
            rf_we_nxt    = 1'b1;
            rf_waddr_nxt = bus.rd;
            rf_wdata_nxt = bus.r;
         end
      end
   end

   assign bus.in_ready  = rst && ready_c;
   assign bus.rf_we     = rf_we;
   assign bus.rf_waddr  = rf_waddr;
   assign bus.rf_wdata  = rf_wdata;
   assign bus.exc_pulse = exc_pulse;
   assign bus.exc_count = exc_count;
endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios then random traffic, checked every
// cycle against a per-cycle schedule of expected register-file writes.
`timescale 1ns/1ps
module tb_alu_writeback;
   localparam int unsigned HI_REG = 0;

   typedef struct packed {
      logic        we;
      logic [3:0]  addr;
      logic [15:0] data;
      logic        pulse;
      logic        ready;
   } slot_t;

   localparam slot_t IDLE_SLOT = '{we: 1'b0, addr: 4'h0, data: 16'h0, pulse: 1'b0, ready: 1'b1};

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   slot_t       cur, nxt, nxt2;
   logic [3:0]  last_addr;
   logic [15:0] last_data;
   int          exp_cnt;
   bit          acc_flag;
   logic [15:0] reg_file [16];

   alu_writeback_if #(.REG_DATA_WIDTH(16), .REG_ADDR_WIDTH(4),
                      .ALU_CONTROL_WIDTH(4), .EXC_CNT_WIDTH(8)) bus ();

   alu_writeback #(.REG_DATA_WIDTH(16), .REG_ADDR_WIDTH(4), .ALU_CONTROL_WIDTH(4),
                   .HI_REG(HI_REG), .EXC_CNT_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cur = IDLE_SLOT; nxt = IDLE_SLOT; nxt2 = IDLE_SLOT;
      last_addr = 4'h0; last_data = 16'h0; exp_cnt = 0;
   endtask

   // One clock: schedule effects of this cycle's transfer, advance, compare all outputs.
   task automatic tick();
      bit wide;
      acc_flag = bus.in_valid && cur.ready;
      if (acc_flag) begin
         wide = (bus.alu_control == 4'd1) || (bus.alu_control == 4'd2);
         if (bus.exc_alu)
            nxt = '{we: 1'b0, addr: 4'h0, data: 16'h0, pulse: 1'b1, ready: 1'b1};
         else if (!bus.wb_en || bus.alu_control == 4'd0)
            nxt = IDLE_SLOT;
         else begin
            nxt = '{we: 1'b1, addr: bus.rd, data: bus.r, pulse: 1'b0, ready: !wide};
            if (wide) nxt2 = '{we: 1'b1, addr: 4'(HI_REG), data: bus.s, pulse: 1'b0, ready: 1'b1};
         end
      end
      @(posedge clk);
      #1;
      cur = nxt; nxt = nxt2; nxt2 = IDLE_SLOT;
      if (cur.we) begin last_addr = cur.addr; last_data = cur.data; end
      if (cur.pulse && exp_cnt < 255) exp_cnt++;
      if (bus.rf_we === 1'b1) reg_file[bus.rf_waddr] = bus.rf_wdata;
      chk("rf_we",     32'(bus.rf_we),     32'(cur.we));
      chk("rf_waddr",  32'(bus.rf_waddr),  32'(last_addr));
      chk("rf_wdata",  32'(bus.rf_wdata),  32'(last_data));
      chk("exc_pulse", 32'(bus.exc_pulse), 32'(cur.pulse));
      chk("exc_count", 32'(bus.exc_count), 32'(exp_cnt));
      chk("in_ready",  32'(bus.in_ready),  32'(cur.ready));
   endtask

   // Present one op and hold it until accepted (bounded), then drop in_valid.
   task automatic issue(input logic [3:0] ctrl, input logic [15:0] rv, input logic [15:0] sv,
                        input logic exc, input logic [3:0] rdv, input logic wb);
      int n;
      bus.in_valid = 1'b1; bus.alu_control = ctrl; bus.r = rv; bus.s = sv;
      bus.exc_alu = exc; bus.rd = rdv; bus.wb_en = wb;
      n = 0;
      do begin tick(); n++; end while (!acc_flag && n < 8);
      chk("accept_timeout", 32'(acc_flag), 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) reg_file[i] = 16'h0;
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.alu_control = 4'h0; bus.r = 16'h0; bus.s = 16'h0;
      bus.exc_alu = 1'b0; bus.rd = 4'h0; bus.wb_en = 1'b0;
      acc_flag = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rf_we",     32'(bus.rf_we),     32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst_exc_count", 32'(bus.exc_count), 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

      // Single ADD write
      issue(4'd3, 16'h1234, 16'h0, 1'b0, 4'd3, 1'b1);
      chk("add_data", 32'(bus.rf_wdata), 32'h1234);
      idle(2);

      // MUL: lower then upper write
      issue(4'd1, 16'h5678, 16'h0012, 1'b0, 4'd5, 1'b1);
      chk("mul_lo_addr", 32'(bus.rf_waddr), 32'd5);
      chk("mul_lo_rdy",  32'(bus.in_ready), 32'd0);
      idle(1);
      chk("mul_hi_data", 32'(bus.rf_wdata), 32'h0012);
      issue(4'd1, 16'hAAAA, 16'h0012, 1'b0, 4'd0, 1'b1);
      idle(2);
      chk("r0_final", 32'(reg_file[0]), 32'h0012);

      // Back-to-back singles, then DIV followed by ADD held valid
      issue(4'd3, 16'h0101, 16'h0, 1'b0, 4'd1, 1'b1);
      issue(4'd4, 16'h0202, 16'h0, 1'b0, 4'd2, 1'b1);
      issue(4'd5, 16'h0303, 16'h0, 1'b0, 4'd4, 1'b1);
      issue(4'd2, 16'h0404, 16'h0505, 1'b0, 4'd6, 1'b1);
      issue(4'd3, 16'h0606, 16'h0, 1'b0, 4'd7, 1'b1);
      idle(2);
      chk("div_rem", 32'(reg_file[0]), 32'h0505);
      chk("add_after_div", 32'(reg_file[7]), 32'h0606);

      // Faults: no writes, saturating count
      issue(4'd3, 16'hDEAD, 16'h0, 1'b1, 4'd2, 1'b1);
      chk("exc_cnt1", 32'(bus.exc_count), 32'd1);
      idle(1);
      for (int i = 0; i < 300; i++) issue(4'($urandom_range(0, 15)), 16'hBEEF, 16'h0, 1'b1, 4'd2, 1'b1);
      chk("exc_sat", 32'(bus.exc_count), 32'd255);
      chk("no_fault_write", 32'(reg_file[2]), 32'h0202);
      idle(1);

      // Reset during the upper write of a DIV
      issue(4'd2, 16'h1111, 16'h2222, 1'b0, 4'd9, 1'b1);
      tick();
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_we",    32'(bus.rf_we),    32'd0);
      chk("rst_mid_ready", 32'(bus.in_ready), 32'd0);
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_rel_ready", 32'(bus.in_ready), 32'd1);
      idle(2);

      // No-write cases
      issue(4'd3, 16'hFFFF, 16'h0, 1'b0, 4'd8, 1'b0);
      issue(4'd0, 16'hFFFF, 16'h0, 1'b0, 4'd8, 1'b1);
      idle(2);
      chk("no_write_r8", 32'(reg_file[8]), 32'h0);

      // Random traffic, inputs held while not accepted
      acc_flag = 1'b0;
      bus.in_valid = 1'b0;
      repeat (600) begin
         if (!bus.in_valid || acc_flag) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.alu_control = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 2))
                                                          : 4'($urandom_range(0, 15));
            bus.r       = 16'($urandom);
            bus.s       = 16'($urandom);
            bus.exc_alu = ($urandom_range(0, 7) == 0);
            bus.rd      = 4'($urandom_range(0, 15));
            bus.wb_en   = ($urandom_range(0, 5) != 0);
         end
         tick();
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
